mult_accum: RTL and testbench

MULT_ACCUM -- requirements
Module: mult_accum

---
 rtl/mult_accum_pkg.sv | 14 +
 rtl/mult_accum_array_mult.sv | 22 ++
 rtl/mult_accum.sv | 141 ++++++++++++++
 tb/tb_mult_accum.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_accum_pkg.sv
// rtl/mult_accum_pkg.sv - shared FSM state type and default sizing for mult_accum
package mult_accum_pkg;

  localparam int N_DEF     = 4;
  localparam int LEN_DEF   = 8;
  localparam int ACC_W_DEF = 2 * N_DEF + 4;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/mult_accum_array_mult.sv
// rtl/mult_accum_array_mult.sv - combinational NxN unsigned array multiplier
module ArrayMultiplier_NxN
  import mult_accum_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  // Each row of the array adds the shifted multiplicand when its multiplier bit is set.
  always_comb begin
    p = '0;
    for (int i = 0; i < N; i++) begin
      if (b[i]) begin
        p = p + ((2 * N)'(a) << i);
      end
    end
  end

endmodule

// File: rtl/mult_accum.sv
// rtl/mult_accum.sv - two-stage multiply-accumulate over fixed-length frames
// MULT_ACCUM_SATURATE_EN: clamp the accumulator on overflow instead of wrapping
module mult_accum
  import mult_accum_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LEN   = LEN_DEF,
  parameter int ACC_W = 2 * N + 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             s1_valid_q, s1_valid_d;
  logic [N-1:0]     s1_a_q, s1_a_d;
  logic [N-1:0]     s1_b_q, s1_b_d;
  logic             s2_valid_q, s2_valid_d;
  logic [2*N-1:0]   s2_prod_q, s2_prod_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic [2*N-1:0]   prod;
  logic [ACC_W:0]   sum;
  logic             accept;

  ArrayMultiplier_NxN #(.N(N)) u_mult (
    .a (s1_a_q),
    .b (s1_b_q),
    .p (prod)
  );

  // Gated by rst_n so every output reads zero while reset is held.
  assign in_ready  = (state_q == ACCUM) && rst_n;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    s1_valid_d = accept;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s1_valid_q;
    s2_prod_d  = prod;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    sum        = {1'b0, acc_q} + (ACC_W + 1)'(s2_prod_q);

    if (accept) begin
      s1_a_d = a;
      s1_b_d = b;
    end

    if (s2_valid_q) begin
      ovf_d = ovf_q | sum[ACC_W];
`ifdef MULT_ACCUM_SATURATE_EN
      acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
      acc_d = sum[ACC_W-1:0];
`endif
    end

    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (count_q == LAST) begin
            count_d = '0;
            state_d = DRAIN;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      // Last product sits in stage 2 once stage 1 has emptied.
      DRAIN: begin
        if (!s1_valid_q && s2_valid_q) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase

    if (clear) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      acc_d      = '0;
      ovf_d      = 1'b0;
      count_d    = '0;
      state_d    = ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      count_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_prod_q  <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_prod_q  <= s2_prod_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mult_accum.sv
// tb/tb_mult_accum.sv - scoreboard bench for mult_accum (LEN=4/ACC_W=12 and LEN=8/ACC_W=10)
module tb_mult_accum;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        clear0 = 0, in_valid0 = 0, out_ready0 = 0;
  logic [3:0]  a0 = 0, b0 = 0;
  logic        in_ready0, out_valid0, ovf0;
  logic [11:0] acc0;

  logic        clear1 = 0, in_valid1 = 0, out_ready1 = 0;
  logic [3:0]  a1 = 0, b1 = 0;
  logic        in_ready1, out_valid1, ovf1;
  logic [9:0]  acc1;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_acc0[$], exp_ovf0[$], exp_acc1[$], exp_ovf1[$];

  mult_accum #(.N(4), .LEN(4), .ACC_W(12)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear0), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .out_valid(out_valid0), .out_ready(out_ready0), .acc_out(acc0), .ovf(ovf0)
  );

  mult_accum #(.N(4), .LEN(8), .ACC_W(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1), .acc_out(acc1), .ovf(ovf1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitors: a handshake visible at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid0 && out_ready0 && !clear0) begin
      if (exp_acc0.size() == 0) begin
        chk("dut0_unexpected_result", int'(acc0), -1);
      end else begin
        chk("dut0_acc", int'(acc0), exp_acc0.pop_front());
        chk("dut0_ovf", int'(ovf0), exp_ovf0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid1 && out_ready1 && !clear1) begin
      if (exp_acc1.size() == 0) begin
        chk("dut1_unexpected_result", int'(acc1), -1);
      end else begin
        chk("dut1_acc", int'(acc1), exp_acc1.pop_front());
        chk("dut1_ovf", int'(ovf1), exp_ovf1.pop_front());
      end
    end
  end

  task automatic send0(input int av, input int bv);
    int k;
    in_valid0 = 1'b1;
    a0 = 4'(av);
    b0 = 4'(bv);
    k = 0;
    while (!in_ready0 && k < 20) begin
      step();
      k++;
    end
    if (k >= 20) chk("dut0_in_ready_timeout", 0, 1);
    step();
    in_valid0 = 1'b0;
  endtask

  task automatic wait_done0();
    int k;
    k = 0;
    while (!(out_valid0 && out_ready0) && k < 40) begin
      step();
      k++;
    end
    if (k >= 40) chk("dut0_out_valid_timeout", 0, 1);
    else step();
  endtask

  initial begin
    int k;
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    #1;
    chk("reset_out_valid", int'(out_valid0), 0);
    chk("reset_acc", int'(acc0), 0);
    chk("reset_ovf", int'(ovf0), 0);
    chk("reset_in_ready", int'(in_ready0), 0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", int'(in_ready0), 1);
    step();

    // Four back-to-back (15,15): result two edges after the last accept.
    out_ready0 = 1'b1;
    exp_acc0.push_back(900); exp_ovf0.push_back(0);
    for (int i = 0; i < 4; i++) send0(15, 15);
    chk("lat_e0_out_valid", int'(out_valid0), 0);
    chk("drain_in_ready", int'(in_ready0), 0);
    step();
    chk("lat_e1_out_valid", int'(out_valid0), 0);
    step();
    chk("lat_e2_out_valid", int'(out_valid0), 1);
    step();
    chk("after_hs_in_ready", int'(in_ready0), 1);
    chk("after_hs_acc", int'(acc0), 0);

    // Same frame with back-pressure held for five cycles.
    out_ready0 = 1'b0;
    exp_acc0.push_back(900); exp_ovf0.push_back(0);
    for (int i = 0; i < 4; i++) send0(15, 15);
    k = 0;
    while (!out_valid0 && k < 10) begin step(); k++; end
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", int'(out_valid0), 1);
      chk("hold_in_ready", int'(in_ready0), 0);
      chk("hold_acc", int'(acc0), 900);
      step();
    end
    out_ready0 = 1'b1;
    step();
    chk("hold_release_in_ready", int'(in_ready0), 1);
    exp_acc0.push_back(8); exp_ovf0.push_back(0);
    for (int i = 0; i < 4; i++) send0(1, 2);
    wait_done0();

    // Separate frame on the LEN=8 ACC_W=10 instance: overflow.
    out_ready1 = 1'b1;
`ifdef MULT_ACCUM_SATURATE_EN
    exp_acc1.push_back(1023);
`else
    exp_acc1.push_back(776);
`endif
    exp_ovf1.push_back(1);
    for (int i = 0; i < 8; i++) begin
      in_valid1 = 1'b1; a1 = 4'd15; b1 = 4'd15;
      k = 0;
      while (!in_ready1 && k < 20) begin step(); k++; end
      step();
    end
    in_valid1 = 1'b0;
    k = 0;
    while (!(out_valid1 && out_ready1) && k < 40) begin step(); k++; end
    if (k >= 40) chk("dut1_out_valid_timeout", 0, 1);
    else step();

    // in_valid bubbles with (3,5): exactly four terms.
    exp_acc0.push_back(60); exp_ovf0.push_back(0);
    a0 = 4'd3; b0 = 4'd5;
    for (int i = 0; i < 7; i++) begin
      in_valid0 = pat[i][0];
      step();
    end
    in_valid0 = 1'b0;
    wait_done0();

    // clear mid-frame discards the (7,7) terms.
    send0(7, 7);
    send0(7, 7);
    clear0 = 1'b1;
    step();
    clear0 = 1'b0;
    chk("clear_acc", int'(acc0), 0);
    step();
    step();
    chk("clear_flush_acc", int'(acc0), 0);
    exp_acc0.push_back(4); exp_ovf0.push_back(0);
    for (int i = 0; i < 4; i++) send0(1, 1);
    wait_done0();

    // clear coincident with out_ready in HOLD drops the result.
    out_ready0 = 1'b0;
    for (int i = 0; i < 4; i++) send0(2, 3);
    k = 0;
    while (!out_valid0 && k < 10) begin step(); k++; end
    chk("pre_clear_hold_acc", int'(acc0), 24);
    out_ready0 = 1'b1;
    clear0 = 1'b1;
    step();
    clear0 = 1'b0;
    chk("clear_hold_out_valid", int'(out_valid0), 0);
    chk("clear_hold_acc", int'(acc0), 0);
    chk("clear_hold_in_ready", int'(in_ready0), 1);

    // Asynchronous reset mid-frame.
    send0(9, 9);
    send0(9, 9);
    step();
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_acc", int'(acc0), 0);
    chk("async_rst_out_valid", int'(out_valid0), 0);
    chk("async_rst_ovf", int'(ovf0), 0);
    chk("async_rst_in_ready", int'(in_ready0), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", int'(in_ready0), 1);
    chk("post_rst_acc", int'(acc0), 0);
    exp_acc0.push_back(16); exp_ovf0.push_back(0);
    for (int i = 0; i < 4; i++) send0(2, 2);
    wait_done0();

    step();
    chk("dut0_queue_drained", exp_acc0.size(), 0);
    chk("dut1_queue_drained", exp_acc1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got %0d tests expected completion", n_tests);
    $fatal(1, "timeout");
  end

endmodule
